bcd_conv_arbiter: RTL and testbench

Round-robin scheduler that shares one multi-cycle binary-to-BCD converter among N_REQ requesters, such as the display digit groups of the TM1638 front end. It grants one requester at a time and launches the converter with a one-cycle start pulse. It waits for the converter's done pulse, with a timeout, and returns the BCD result tagged with the requester ID over a valid/ready response port.

---
 rtl/bcd_conv_arbiter.sv | 145 ++++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one multi-cycle binary-to-BCD converter among N_REQ requesters.
// Issues a one-cycle start pulse, waits for done or timeout, returns a tagged valid/ready response.
module bcd_conv_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned BIN_W       = 8,
  parameter int unsigned BCD_W       = 12,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BIN_W-1:0] req_bin,
  output logic [N_REQ-1:0]       gnt,
  output logic                   conv_start,
  output logic [BIN_W-1:0]       conv_bin,
  input  logic                   conv_done,
  input  logic [BCD_W-1:0]       conv_bcd,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [BCD_W-1:0]       rsp_bcd,
  output logic                   rsp_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             start_q, start_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             err_q, err_d;

  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand;
  logic             found;

  // Search last+1, last+2, ... modulo N_REQ; descending loop leaves the nearest hit in winner.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(last_q) + i) % N_REQ);
      if (req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    gnt_d   = '0;
    start_d = 1'b0;
    bin_d   = bin_q;
    valid_d = valid_q;
    id_d    = id_q;
    bcd_d   = bcd_q;
    err_d   = err_q;

    case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = N_REQ'(1) << winner;
          start_d = 1'b1;
          bin_d   = req_bin[winner*BIN_W +: BIN_W];
          id_d    = winner;
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        // Done takes precedence over a timeout falling on the same cycle.
        if (conv_done) begin
          bcd_d   = conv_bcd;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = StResp;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          bcd_d   = {BCD_W{1'b1}};
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (valid_q && rsp_ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          last_d  = id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      last_q  <= ID_W'(N_REQ - 1);
      timer_q <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
    end
  end

  assign gnt        = gnt_q;
  assign conv_start = start_q;
  assign conv_bin   = bin_q;
  assign rsp_valid  = valid_q;
  assign rsp_id     = id_q;
  assign rsp_bcd    = bcd_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: the bench plays the converter and the response consumer.
module tb_bcd_conv_arbiter;

  localparam int unsigned N_REQ       = 4;
  localparam int unsigned BIN_W       = 8;
  localparam int unsigned BCD_W       = 12;
  localparam int unsigned TIMEOUT_CYC = 64;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*BIN_W-1:0] req_bin;
  logic [N_REQ-1:0]       gnt;
  logic                   conv_start;
  logic [BIN_W-1:0]       conv_bin;
  logic                   conv_done;
  logic [BCD_W-1:0]       conv_bcd;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic [BCD_W-1:0]       rsp_bcd;
  logic                   rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  bcd_conv_arbiter #(
    .N_REQ      (N_REQ),
    .BIN_W      (BIN_W),
    .BCD_W      (BCD_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_bin   (req_bin),
    .gnt       (gnt),
    .conv_start(conv_start),
    .conv_bin  (conv_bin),
    .conv_done (conv_done),
    .conv_bcd  (conv_bcd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_bcd   (rsp_bcd),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".gnt"}, 32'(gnt), 0);
    check({tag, ".conv_start"}, 32'(conv_start), 0);
    check({tag, ".conv_bin"}, 32'(conv_bin), 0);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, ".rsp_id"}, 32'(rsp_id), 0);
    check({tag, ".rsp_bcd"}, 32'(rsp_bcd), 0);
    check({tag, ".rsp_err"}, 32'(rsp_err), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Waits (bounded) for a grant, checks it, optionally drops req, then checks the pulses end.
  task automatic wait_grant(input int id, input logic [7:0] bin, input bit drop);
    int n = 0;
    while (gnt == '0 && n < 200) begin
      tick();
      n++;
    end
    check("grant_onehot", 32'(gnt), 32'(4'(1) << id));
    check("grant_start", 32'(conv_start), 1);
    check("grant_bin", 32'(conv_bin), 32'(bin));
    check("grant_id", 32'(rsp_id), 32'(id));
    if (drop) req[id] = 1'b0;
    tick();
    check("gnt_pulse_end", 32'(gnt), 0);
    check("start_pulse_end", 32'(conv_start), 0);
  endtask

  task automatic complete(input int lat, input logic [11:0] bcd, input int id);
    repeat (lat) tick();
    conv_done = 1'b1;
    conv_bcd  = bcd;
    tick();
    conv_done = 1'b0;
    conv_bcd  = '0;
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_bcd", 32'(rsp_bcd), 32'(bcd));
    check("rsp_err", 32'(rsp_err), 0);
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    tick();
    check("rsp_accepted", 32'(rsp_valid), 0);
  endtask

  initial begin
    rst       = 1'b0;
    req       = '0;
    req_bin   = {8'd198, 8'd76, 8'd5, 8'd243};
    conv_done = 1'b0;
    conv_bcd  = '0;
    rsp_ready = 1'b0;

    do_reset();
    check_idle_outputs("reset");

    // Single request from requester 0
    req = 4'b0001;
    wait_grant(0, 8'd243, 1'b1);
    complete(20, 12'h243, 0);
    accept();
    repeat (3) tick();
    check("single_no_regrant", 32'(gnt), 0);

    // Fairness with all requests held; reset returns priority to requester 0
    do_reset();
    req = 4'b1111;
    wait_grant(0, 8'd243, 1'b0);
    complete(8, 12'h243, 0);
    accept();
    wait_grant(1, 8'd5, 1'b0);
    complete(8, 12'h005, 1);
    accept();
    wait_grant(2, 8'd76, 1'b0);
    complete(8, 12'h076, 2);
    accept();
    wait_grant(3, 8'd198, 1'b0);
    complete(8, 12'h198, 3);
    accept();
    wait_grant(0, 8'd243, 1'b0);
    req = 4'b0000;
    complete(8, 12'h243, 0);
    accept();

    // Backpressure with a pending request from requester 1
    rsp_ready = 1'b0;
    req = 4'b0001;
    wait_grant(0, 8'd243, 1'b1);
    complete(6, 12'h243, 0);
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_id", 32'(rsp_id), 0);
      check("bp_bcd", 32'(rsp_bcd), 32'h243);
      check("bp_no_gnt", 32'(gnt), 0);
      check("bp_bin_hold", 32'(conv_bin), 243);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_accept_valid", 32'(rsp_valid), 0);
    check("bp_accept_no_gnt", 32'(gnt), 0);
    tick();
    check("bp_gnt1_second_edge", 32'(gnt), 32'b0010);
    wait_grant(1, 8'd5, 1'b1);
    complete(10, 12'h005, 1);
    accept();

    // Timeout: converter stays silent
    req = 4'b0100;
    wait_grant(2, 8'd76, 1'b1);
    repeat (TIMEOUT_CYC - 2) tick();
    check("to_not_yet", 32'(rsp_valid), 0);
    tick();
    check("to_valid", 32'(rsp_valid), 1);
    check("to_bcd", 32'(rsp_bcd), 32'hFFF);
    check("to_err", 32'(rsp_err), 1);
    check("to_id", 32'(rsp_id), 2);
    accept();
    check("to_err_cleared", 32'(rsp_err), 0);
    req = 4'b0001;
    wait_grant(0, 8'd243, 1'b1);
    complete(5, 12'h243, 0);
    accept();

    // Reset mid-WAIT followed by a late done
    req = 4'b0001;
    wait_grant(0, 8'd243, 1'b1);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_idle_outputs("mid_reset");
    tick();
    conv_done = 1'b1;
    conv_bcd  = 12'h243;
    tick();
    conv_done = 1'b0;
    conv_bcd  = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("late_done_ignored", 32'(rsp_valid), 0);
    end
    // Pointer was reset, so 0 beats 3 even though 0 was served last
    req = 4'b1001;
    wait_grant(0, 8'd243, 1'b1);
    complete(4, 12'h243, 0);
    accept();
    wait_grant(3, 8'd198, 1'b1);
    complete(4, 12'h198, 3);
    accept();

    // Done arriving on the timeout cycle wins
    req = 4'b0100;
    wait_grant(2, 8'd76, 1'b1);
    repeat (TIMEOUT_CYC - 2) tick();
    check("coinc_not_yet", 32'(rsp_valid), 0);
    complete(0, 12'h076, 2);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
